wb_fabric_decoder: RTL and testbench
====================================

// Module: wb_fabric_decoder
// PURPOSE
//  Wishbone slave-side address decoder and ack arbiter. Sits directly downstream of the
//  qlal4s3b_cell_macro AHB-to-FPGA bridge and upstream of four fabric slaves:
//  FPGA regs, UART0, UART1 and QL-reserved.
//  - Routes CYC to the addressed slave and muxes its ACK/RD_DAT back to the bridge.
//  - Ends cycles no slave answers with a default-value ack after a timeout, so the M4 never hangs.
//  - Keeps a sticky timeout flag and captures the faulting address.
// PARAMETERS
//  APERWIDTH             17            byte-address width of WBs_ADR
//  APERSIZE              10            word-address bits per slave window (4 KB window)
//  FPGA_REG_BASE_ADDRESS 17'h00000     slave 0 window base
//  UART0_BASE_ADDRESS    17'h01000     slave 1 window base
//  UART1_BASE_ADDRESS    17'h02000     slave 2 window base
//  QL_RESERVED_BASE_ADDRESS 17'h03000  slave 3 window base
//  DEFAULT_READ_VALUE    32'hBAD_FAB_AC  RD_DAT returned on timeout ack
//  DEFAULT_CNTR_WIDTH    3             timeout counter width; must hold DEFAULT_CNTR_TIMEOUT
//  DEFAULT_CNTR_TIMEOUT  7             strobe cycles without ack before default ack
// PORTS
//  WB_CLK          in   1    Wishbone/fabric clock
//  WB_RST          in   1    synchronous reset, active-high
//  WBs_ADR         in   17   byte address from bridge
//  WBs_CYC         in   1    cycle select from bridge
//  WBs_STB         in   1    strobe from bridge
//  WBs_WE          in   1    write enable (used only for timeout capture)
//  WBs_RD_DAT      out  32   read data to bridge
//  WBs_ACK         out  1    ack to bridge
//  WBs_CYC_SEL_o   out  4    per-slave CYC, bit n = slave n
//  WBs_ACK_SLV_i   in   4    per-slave ack
//  WBs_RD_DAT_SLV_i in  128  per-slave read data, slave n at [32n+31:32n]
//  Timeout_Flag_o  out  1    sticky: a default ack has occurred
//  Timeout_Adr_o   out  17   WBs_ADR of the most recent timed-out cycle
//  Timeout_WE_o    out  1    WBs_WE of the most recent timed-out cycle
//  Timeout_Clr_i   in   1    clears Timeout_Flag_o
// BEHAVIOUR
//  - Decode (combinational): hit[n] = (WBs_ADR[16:12] == BASE_n[16:12]).
//    WBs_CYC_SEL_o[n] = WBs_CYC & hit[n]. Addresses outside all windows select no slave.
//  - Ack path: slave_ack = |(WBs_ACK_SLV_i & hit) & WBs_CYC & WBs_STB.
//    WBs_ACK = slave_ack | to_ack, gated to 0 in state DONE.
//    WBs_RD_DAT = to_ack ? DEFAULT_READ_VALUE : data of the hit slave (0 if none).
//  - FSM states:
//    - IDLE: cnt = 0.
//      - CYC & STB with no slave_ack -> WAIT, cnt = 1.
//      - CYC & STB with slave_ack -> DONE.
//    - WAIT: cnt increments each cycle while CYC & STB and no slave_ack.
//      - slave_ack -> DONE.
//      - cnt == DEFAULT_CNTR_TIMEOUT -> to_ack (registered), asserted for exactly one cycle, then DONE.
//      - CYC or STB low -> IDLE, cnt = 0, no ack (abort).
//    - DONE: exactly one cycle, all acks masked (the bridge drops STB the cycle after ACK), -> IDLE.
//  - Latency: slave ack is pass-through (0 added cycles). The timeout ack appears on the
//    (DEFAULT_CNTR_TIMEOUT+1)th cycle of STB; with defaults, cycle t0+7 for STB rising at t0.
//  - cnt saturates and never wraps. DEFAULT_CNTR_TIMEOUT = 0 is illegal.
//  - Slave ack in the same cycle as to_ack would fire: the slave wins, its data is returned,
//    no flag is set and no capture occurs.
//  - Timeout capture: on to_ack, Timeout_Flag_o <= 1 and Timeout_Adr_o/Timeout_WE_o are loaded.
//    Timeout_Clr_i and to_ack in the same cycle: set wins and the address is updated.
//  - Reset (also mid-cycle): state IDLE, cnt 0, no ack issued, WBs_ACK 0, Timeout_Flag_o 0,
//    Timeout_Adr_o 0, Timeout_WE_o 0. WBs_CYC_SEL_o and WBs_RD_DAT follow the inputs combinationally.
// STRUCTURE
//  - Shared package wb_fabric_pkg holds: slave index constants (SLV_FPGA_REG=0, SLV_UART0=1,
//    SLV_UART1=2, SLV_QL_RSVD=3), the window base constants, and the FSM state encoding
//    (IDLE, WAIT, DONE).
//  - One sub-module, wb_ack_timer, holds the FSM plus counter and outputs to_ack and the
//    done mask. Decode, mux and capture logic stay in the top.
// TESTING
//  1. Read 17'h01004, UART0 acks 2 cycles after STB with 32'h0000_00A5
//     -> CYC_SEL=4'b0010, WBs_ACK 1 cycle, RD_DAT=32'h0000_00A5, flag stays 0.
//  2. Read 17'h05000 (unmapped) -> CYC_SEL=0, ACK at STB+7, RD_DAT=32'hBAD_FAB_AC,
//     Timeout_Flag_o=1, Timeout_Adr_o=17'h05000, Timeout_WE_o=0.
//  3. Write 17'h02010 where UART1 acks exactly on cycle STB+7 -> single ACK, slave data path, flag 0.
//  4. STB dropped at STB+3 with no ack -> no ACK. The next cycle to a silent slave times out at
//     its own STB+7, not earlier.
//  5. Timeout_Clr_i pulsed in the same cycle as a timeout ack -> flag remains 1.
//     Clr pulsed alone afterwards -> flag 0.
//  6. WB_RST asserted at STB+4 of a timing-out cycle -> no ACK ever issued, flag 0,
//     FSM accepts a new cycle immediately after reset releases.

Source files
------------

// File: rtl/wb_fabric_pkg.sv
// ---------------------------------------------------------------------------
// wb_fabric_pkg
//
// Shared definitions for the Wishbone fabric decoder slice.
//
// Contents:
//    - slave index constants: the bit position of each fabric slave in
//      every per-slave vector (CYC select, ack, read-data lanes)
//    - default window base addresses for the four slave windows
//    - the default read value returned when a cycle times out
//    - the state encoding of the ack timer FSM
// ---------------------------------------------------------------------------
package wb_fabric_pkg;

   // Bit position of each fabric slave in the per-slave vectors.
   localparam int NUM_SLAVES   = 4;
   localparam int SLV_FPGA_REG = 0;
   localparam int SLV_UART0    = 1;
   localparam int SLV_UART1    = 2;
   localparam int SLV_QL_RSVD  = 3;

   // Byte-address bases of the four 4 KB slave windows.
   localparam logic [16:0] FPGA_REG_BASE_ADDRESS    = 17'h00000;
   localparam logic [16:0] UART0_BASE_ADDRESS       = 17'h01000;
   localparam logic [16:0] UART1_BASE_ADDRESS       = 17'h02000;
   localparam logic [16:0] QL_RESERVED_BASE_ADDRESS = 17'h03000;

   // Recognisable pattern handed back to the M4 when nobody answered.
   localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC;

   // Ack timer states.
   //    IDLE : no cycle in progress
   //    WAIT : strobe is up and no slave has answered yet
   //    DONE : the single cycle after an ack, used to mask stale acks
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } ack_state_t;

endpackage

// File: rtl/wb_ack_timer.sv
// ---------------------------------------------------------------------------
// wb_ack_timer
//
// Watches the Wishbone strobe and the already-decoded slave ack and, when no
// slave answers within the timeout, produces a one-cycle default ack so that
// the bus master can never hang on an unmapped or dead slave. Also provides
// the one-cycle mask that follows every ack.
//
// Ports:
//    clock      in   fabric clock
//    reset      in   synchronous reset, active-high
//    req        in   CYC & STB from the bridge
//    slave_ack  in   ack of the addressed slave, already qualified by req
//    to_ack     out  default (timeout) ack, high for exactly one cycle
//    done_mask  out  high during the cycle after any ack; all acks masked
//
// Counting: the FSM leaves IDLE with cnt = 1 on the first strobe cycle, so
// cnt equals the number of strobe cycles already seen. The registered
// to_ack_q is raised on the edge that brings cnt to CNTR_TIMEOUT, which puts
// the timeout ack on strobe cycle CNTR_TIMEOUT+1. CNTR_TIMEOUT must be at
// least 1 and must fit in CNTR_WIDTH bits.
// ---------------------------------------------------------------------------
module wb_ack_timer #(
   parameter int CNTR_WIDTH   = 3,
   parameter int CNTR_TIMEOUT = 7
) (
   input  logic clock,
   input  logic reset,
   input  logic req,
   input  logic slave_ack,
   output logic to_ack,
   output logic done_mask
);

   import wb_fabric_pkg::*;

   localparam logic [CNTR_WIDTH-1:0] TIMEOUT_VAL = CNTR_WIDTH'(CNTR_TIMEOUT);
   localparam logic [CNTR_WIDTH-1:0] TIMEOUT_M1  = CNTR_WIDTH'(CNTR_TIMEOUT - 1);
   localparam logic [CNTR_WIDTH-1:0] CNT_ONE     = CNTR_WIDTH'(1);

   ack_state_t            state_q;
   logic [CNTR_WIDTH-1:0] cnt_q;
   logic                  to_ack_q;

   // Single FSM holding state, strobe counter and the registered timeout
   // request. A timeout only fires from WAIT; a slave ack always wins over
   // a pending timeout, and dropping CYC or STB abandons the cycle without
   // any ack. The counter stops at the timeout value so it can never wrap
   // around and fire a second time.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         to_ack_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q    <= '0;
               to_ack_q <= 1'b0;
               if (req) begin
                  if (slave_ack) begin
                     state_q <= DONE;
                  end else begin
                     state_q  <= WAIT;
                     cnt_q    <= CNT_ONE;
                     to_ack_q <= (TIMEOUT_VAL == CNT_ONE);
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  state_q  <= IDLE;
                  cnt_q    <= '0;
                  to_ack_q <= 1'b0;
               end else if (slave_ack || to_ack_q) begin
                  state_q  <= DONE;
                  cnt_q    <= '0;
                  to_ack_q <= 1'b0;
               end else begin
                  if (cnt_q != TIMEOUT_VAL) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
                  to_ack_q <= (cnt_q == TIMEOUT_M1);
               end
            end
            DONE: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               to_ack_q <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               to_ack_q <= 1'b0;
            end
         endcase
      end
   end

   // The registered timeout request only becomes a real ack while the
   // strobe is still up and the slave is not answering in the same cycle;
   // otherwise the slave's own ack (or the abort) takes precedence.
   assign to_ack    = to_ack_q & req & ~slave_ack & (state_q == WAIT);
   assign done_mask = (state_q == DONE);

endmodule

// File: rtl/wb_fabric_decoder.sv
// ---------------------------------------------------------------------------
// wb_fabric_decoder
//
// Wishbone slave-side address decoder and ack arbiter sitting between the
// AHB-to-FPGA bridge and four fabric slaves (FPGA regs, UART0, UART1,
// QL-reserved).
//
// Ports:
//    WB_CLK            in   fabric clock
//    WB_RST            in   synchronous reset, active-high
//    WBs_ADR           in   byte address from the bridge
//    WBs_CYC           in   cycle select from the bridge
//    WBs_STB           in   strobe from the bridge
//    WBs_WE            in   write enable, only recorded on a timeout
//    WBs_RD_DAT        out  read data to the bridge
//    WBs_ACK           out  ack to the bridge
//    WBs_CYC_SEL_o     out  per-slave CYC, bit n = slave n
//    WBs_ACK_SLV_i     in   per-slave ack
//    WBs_RD_DAT_SLV_i  in   per-slave read data, slave n at [32n+31:32n]
//    Timeout_Flag_o    out  sticky flag: a default ack has happened
//    Timeout_Adr_o     out  address of the most recent timed-out cycle
//    Timeout_WE_o      out  write enable of the most recent timed-out cycle
//    Timeout_Clr_i     in   clears Timeout_Flag_o
//
// Decode, read-data mux and timeout capture live here; the strobe timer and
// its FSM live in wb_ack_timer.
// ---------------------------------------------------------------------------
module wb_fabric_decoder #(
   parameter int                  APERWIDTH                = 17,
   parameter int                  APERSIZE                 = 10,
   parameter logic [APERWIDTH-1:0] FPGA_REG_BASE_ADDRESS    = wb_fabric_pkg::FPGA_REG_BASE_ADDRESS,
   parameter logic [APERWIDTH-1:0] UART0_BASE_ADDRESS       = wb_fabric_pkg::UART0_BASE_ADDRESS,
   parameter logic [APERWIDTH-1:0] UART1_BASE_ADDRESS       = wb_fabric_pkg::UART1_BASE_ADDRESS,
   parameter logic [APERWIDTH-1:0] QL_RESERVED_BASE_ADDRESS = wb_fabric_pkg::QL_RESERVED_BASE_ADDRESS,
   parameter logic [31:0]          DEFAULT_READ_VALUE       = wb_fabric_pkg::DEFAULT_READ_VALUE,
   parameter int                  DEFAULT_CNTR_WIDTH       = 3,
   parameter int                  DEFAULT_CNTR_TIMEOUT     = 7
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RST,
   input  logic [APERWIDTH-1:0] WBs_ADR,
   input  logic                 WBs_CYC,
   input  logic                 WBs_STB,
   input  logic                 WBs_WE,
   output logic [31:0]          WBs_RD_DAT,
   output logic                 WBs_ACK,
   output logic [3:0]           WBs_CYC_SEL_o,
   input  logic [3:0]           WBs_ACK_SLV_i,
   input  logic [127:0]         WBs_RD_DAT_SLV_i,
   output logic                 Timeout_Flag_o,
   output logic [APERWIDTH-1:0] Timeout_Adr_o,
   output logic                 Timeout_WE_o,
   input  logic                 Timeout_Clr_i
);

   import wb_fabric_pkg::*;

   // APERSIZE counts word-address bits, so the window select starts two
   // bits higher in the byte address.
   localparam int WIN_LSB = APERSIZE + 2;

   logic [NUM_SLAVES-1:0] hit;
   logic                  req;
   logic                  slave_ack;
   logic                  to_ack;
   logic                  done_mask;
   logic [31:0]           slv_rd_dat;

   // Window decode: a slave is hit when the address bits above its window
   // match its base. Addresses outside every window leave hit all-zero, so
   // no slave is selected and only the timeout can end that cycle.
   always_comb begin
      hit               = '0;
      hit[SLV_FPGA_REG] = (WBs_ADR[APERWIDTH-1:WIN_LSB] == FPGA_REG_BASE_ADDRESS[APERWIDTH-1:WIN_LSB]);
      hit[SLV_UART0]    = (WBs_ADR[APERWIDTH-1:WIN_LSB] == UART0_BASE_ADDRESS[APERWIDTH-1:WIN_LSB]);
      hit[SLV_UART1]    = (WBs_ADR[APERWIDTH-1:WIN_LSB] == UART1_BASE_ADDRESS[APERWIDTH-1:WIN_LSB]);
      hit[SLV_QL_RSVD]  = (WBs_ADR[APERWIDTH-1:WIN_LSB] == QL_RESERVED_BASE_ADDRESS[APERWIDTH-1:WIN_LSB]);
   end

   assign WBs_CYC_SEL_o = hit & {NUM_SLAVES{WBs_CYC}};
   assign req           = WBs_CYC & WBs_STB;

   // Only the addressed slave may ack; acks from the other slaves are noise
   // and are dropped here. The slave ack passes straight through to the
   // bridge with no added latency.
   assign slave_ack = (|(WBs_ACK_SLV_i & hit)) & req;

   // Read-data mux: the lane of the hit slave, or zero when no window is
   // hit. Windows never overlap, so at most one lane is chosen.
   always_comb begin
      slv_rd_dat = '0;
      for (int n = 0; n < NUM_SLAVES; n++) begin
         if (hit[n]) begin
            slv_rd_dat = WBs_RD_DAT_SLV_i[32*n +: 32];
         end
      end
   end

   wb_ack_timer #(
      .CNTR_WIDTH   (DEFAULT_CNTR_WIDTH),
      .CNTR_TIMEOUT (DEFAULT_CNTR_TIMEOUT)
   ) u_ack_timer (
      .clock     (WB_CLK),
      .reset     (WB_RST),
      .req       (req),
      .slave_ack (slave_ack),
      .to_ack    (to_ack),
      .done_mask (done_mask)
   );

   // The bridge drops STB one cycle after it sees ACK, so any ack showing up
   // in that following cycle is stale and must not reach the bridge.
   assign WBs_ACK    = (slave_ack | to_ack) & ~done_mask;
   assign WBs_RD_DAT = to_ack ? DEFAULT_READ_VALUE : slv_rd_dat;

   // Timeout capture: every default ack sets the sticky flag and records the
   // address and direction of the offending cycle. A clear arriving in the
   // same cycle as a timeout loses, so no timeout event is ever missed.
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         Timeout_Flag_o <= 1'b0;
         Timeout_Adr_o  <= '0;
         Timeout_WE_o   <= 1'b0;
      end else if (to_ack) begin
         Timeout_Flag_o <= 1'b1;
         Timeout_Adr_o  <= WBs_ADR;
         Timeout_WE_o   <= WBs_WE;
      end else if (Timeout_Clr_i) begin
         Timeout_Flag_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_fabric_decoder.sv
// ---------------------------------------------------------------------------
// tb_wb_fabric_decoder
//
// Self-checking bench for wb_fabric_decoder. Each bus cycle is described by
// its address, direction, which slaves raise ack and after how many strobe
// cycles, an optional early strobe drop and an optional clear pulse. The
// expected ack cycle, read data and timeout capture are worked out from the
// bus rules directly for the whole transaction before it is driven.
// ---------------------------------------------------------------------------
module tb_wb_fabric_decoder;

   localparam logic [31:0] EXP_DEFAULT = 32'hBADFABAC;
   localparam int          TIMEOUT     = 7;

   logic         WB_CLK = 1'b0;
   logic         WB_RST;
   logic [16:0]  WBs_ADR;
   logic         WBs_CYC;
   logic         WBs_STB;
   logic         WBs_WE;
   logic [31:0]  WBs_RD_DAT;
   logic         WBs_ACK;
   logic [3:0]   WBs_CYC_SEL_o;
   logic [3:0]   WBs_ACK_SLV_i;
   logic [127:0] WBs_RD_DAT_SLV_i;
   logic         Timeout_Flag_o;
   logic [16:0]  Timeout_Adr_o;
   logic         Timeout_WE_o;
   logic         Timeout_Clr_i;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] slv_data [4];
   logic        flag_m;
   logic [16:0] adr_m;
   logic        we_m;

   wb_fabric_decoder dut (
      .WB_CLK           (WB_CLK),
      .WB_RST           (WB_RST),
      .WBs_ADR          (WBs_ADR),
      .WBs_CYC          (WBs_CYC),
      .WBs_STB          (WBs_STB),
      .WBs_WE           (WBs_WE),
      .WBs_RD_DAT       (WBs_RD_DAT),
      .WBs_ACK          (WBs_ACK),
      .WBs_CYC_SEL_o    (WBs_CYC_SEL_o),
      .WBs_ACK_SLV_i    (WBs_ACK_SLV_i),
      .WBs_RD_DAT_SLV_i (WBs_RD_DAT_SLV_i),
      .Timeout_Flag_o   (Timeout_Flag_o),
      .Timeout_Adr_o    (Timeout_Adr_o),
      .Timeout_WE_o     (Timeout_WE_o),
      .Timeout_Clr_i    (Timeout_Clr_i)
   );

   // 100 MHz fabric clock.
   always #5 WB_CLK = ~WB_CLK;

   // Hard stop in case something wedges the run.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic checkCapture(input string tag);
      checkOutput({tag, "_flag"}, 32'(Timeout_Flag_o), 32'(flag_m));
      checkOutput({tag, "_adr"},  32'(Timeout_Adr_o),  32'(adr_m));
      checkOutput({tag, "_we"},   32'(Timeout_WE_o),   32'(we_m));
   endtask

   // One bus cycle. ack_delay: strobe cycle on which the slaves in ack_mask
   // start acking. abort_at: strobe cycle on which STB drops (0 = never).
   // clr_at: strobe cycle carrying a clear pulse (-1 = none). hold_extra
   // keeps STB up one cycle past the ack, where the ack must be masked.
   task automatic applyStimulus(input logic [16:0] addr, input logic we, input logic [3:0] ack_mask,
                                input int ack_delay, input int abort_at, input int clr_at,
                                input bit hold_extra);
      int          slave;
      bit          responding;
      bit          from_slave;
      bit          aborted;
      bit          exp_ack;
      int          ack_cycle;
      int          stb_len;
      int          last;
      logic [3:0]  exp_sel;
      logic [31:0] exp_dat;

      slave      = (addr[16:12] < 5'd4) ? int'(addr[13:12]) : -1;
      responding = 1'b0;
      if (slave >= 0) responding = ack_mask[slave];
      from_slave = responding && (ack_delay <= TIMEOUT);
      ack_cycle  = from_slave ? ack_delay : TIMEOUT;
      aborted    = (abort_at > 0) && (abort_at <= ack_cycle);
      stb_len    = aborted ? abort_at : ack_cycle + 1 + (hold_extra ? 1 : 0);
      last       = aborted ? abort_at : stb_len - 1;
      exp_sel    = (slave >= 0) ? 4'(1 << slave) : 4'b0000;

      for (int i = 0; i < 4; i++) slv_data[i] = $urandom;
      WBs_RD_DAT_SLV_i = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

      for (int c = 0; c <= last; c++) begin
         @(posedge WB_CLK);
         #1;
         WBs_CYC       = (c < stb_len);
         WBs_STB       = (c < stb_len);
         WBs_ADR       = addr;
         WBs_WE        = we;
         WBs_ACK_SLV_i = (c >= ack_delay) ? ack_mask : 4'b0000;
         Timeout_Clr_i = (c == clr_at);
         @(negedge WB_CLK);
         exp_ack = !aborted && (c == ack_cycle);
         checkOutput("ack", 32'(WBs_ACK), 32'(exp_ack));
         if (c == 0) checkOutput("cyc_sel", 32'(WBs_CYC_SEL_o), 32'(exp_sel));
         if (exp_ack) begin
            exp_dat = from_slave ? slv_data[slave] : EXP_DEFAULT;
            checkOutput("rd_dat", WBs_RD_DAT, exp_dat);
         end else if (c == 0 && slave < 0) begin
            checkOutput("rd_dat_unmapped", WBs_RD_DAT, 32'h0);
         end
         if (exp_ack && !from_slave) begin
            flag_m = 1'b1;
            adr_m  = addr;
            we_m   = we;
         end else if (c == clr_at) begin
            flag_m = 1'b0;
         end
      end

      @(posedge WB_CLK);
      #1;
      WBs_CYC       = 1'b0;
      WBs_STB       = 1'b0;
      WBs_ACK_SLV_i = 4'b0000;
      Timeout_Clr_i = 1'b0;
      @(negedge WB_CLK);
      checkOutput("idle_ack", 32'(WBs_ACK), 32'h0);
      checkCapture("capture");
   endtask

   initial begin
      logic [4:0]  win;
      logic [16:0] addr;
      int          abort_at;
      int          clr_at;

      WB_RST           = 1'b1;
      WBs_ADR          = '0;
      WBs_CYC          = 1'b0;
      WBs_STB          = 1'b0;
      WBs_WE           = 1'b0;
      WBs_ACK_SLV_i    = '0;
      WBs_RD_DAT_SLV_i = '0;
      Timeout_Clr_i    = 1'b0;
      flag_m           = 1'b0;
      adr_m            = '0;
      we_m             = 1'b0;

      repeat (2) @(posedge WB_CLK);
      #1;
      WB_RST = 1'b0;
      @(negedge WB_CLK);
      checkOutput("reset_ack", 32'(WBs_ACK), 32'h0);
      checkCapture("reset");

      $display("[TB] directed cycles");
      applyStimulus(17'h01004, 1'b0, 4'b0010, 2, 0, -1, 1'b1);
      applyStimulus(17'h05000, 1'b0, 4'b1111, 0, 0, -1, 1'b0);
      applyStimulus(17'h02010, 1'b1, 4'b0100, 7, 0, -1, 1'b1);
      applyStimulus(17'h03000, 1'b0, 4'b0000, 0, 3, -1, 1'b0);
      applyStimulus(17'h03008, 1'b1, 4'b0000, 0, 0, -1, 1'b0);
      applyStimulus(17'h1F000, 1'b1, 4'b0000, 0, 0, 7, 1'b0);
      applyStimulus(17'h00000, 1'b0, 4'b0001, 1, 0, 0, 1'b0);
      applyStimulus(17'h00ABC, 1'b0, 4'b1110, 0, 0, -1, 1'b1);

      $display("[TB] reset in the middle of a timing-out cycle");
      applyStimulus(17'h06000, 1'b1, 4'b0000, 0, 0, -1, 1'b0);
      for (int c = 0; c <= 8; c++) begin
         @(posedge WB_CLK);
         #1;
         WBs_CYC       = 1'b1;
         WBs_STB       = 1'b1;
         WBs_ADR       = 17'h04000;
         WBs_WE        = 1'b1;
         WBs_ACK_SLV_i = 4'b0000;
         if (c == 4) WB_RST = 1'b1;
         @(negedge WB_CLK);
         checkOutput("rst_mid_ack", 32'(WBs_ACK), 32'h0);
      end
      flag_m = 1'b0;
      adr_m  = '0;
      we_m   = 1'b0;
      @(posedge WB_CLK);
      #1;
      WB_RST  = 1'b0;
      WBs_CYC = 1'b0;
      WBs_STB = 1'b0;
      @(negedge WB_CLK);
      checkCapture("rst_mid");
      applyStimulus(17'h04000, 1'b0, 4'b0000, 0, 0, -1, 1'b0);

      $display("[TB] random cycles");
      repeat (200) begin
         if ($urandom_range(0, 2) == 0) win = 5'($urandom_range(4, 31));
         else                           win = 5'($urandom_range(0, 3));
         addr     = {win, 12'($urandom)};
         abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0;
         clr_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
         applyStimulus(addr, 1'($urandom), 4'($urandom), $urandom_range(0, 10),
                       abort_at, clr_at, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
